// File: rtl/stack_memory_stage_if.sv
// stack_memory_stage_if
//   Request and response bundle between the EX/MEM boundary and the MEM
//   stage. The master side (upstream pipeline) drives the operation request
//   and the pass-through write-back controls; the slave side (the MEM stage)
//   returns the registered MEM/WB fields, the stall request, the fault flags
//   and the current stack pointer.
//   Requests  : mem_read, mem_write, mem_push, mem_pop, wide, address,
//               write_data, reg_write, wb_select, reg_write_addr,
//               alu_result, sign_extend
//   Responses : data_r, reg_write_r, wb_select_r, reg_write_addr_r,
//               alu_result_r, sign_extend_r, stall, stack_fault_r,
//               addr_fault_r, sp
interface stack_memory_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int RA_W   = 3
);
  logic                mem_read;
  logic                mem_write;
  logic                mem_push;
  logic                mem_pop;
  logic                wide;
  logic [DATA_W-1:0]   address;
  logic [2*DATA_W-1:0] write_data;
  logic                reg_write;
  logic                wb_select;
  logic [RA_W-1:0]     reg_write_addr;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   sign_extend;

  logic [2*DATA_W-1:0] data_r;
  logic                reg_write_r;
  logic                wb_select_r;
  logic [RA_W-1:0]     reg_write_addr_r;
  logic [DATA_W-1:0]   alu_result_r;
  logic [DATA_W-1:0]   sign_extend_r;
  logic                stall;
  logic                stack_fault_r;
  logic                addr_fault_r;
  logic [ADDR_W:0]     sp;

  modport master (
    output mem_read, mem_write, mem_push, mem_pop, wide, address, write_data,
           reg_write, wb_select, reg_write_addr, alu_result, sign_extend,
    input  data_r, reg_write_r, wb_select_r, reg_write_addr_r, alu_result_r,
           sign_extend_r, stall, stack_fault_r, addr_fault_r, sp
  );

  modport slave (
    input  mem_read, mem_write, mem_push, mem_pop, wide, address, write_data,
           reg_write, wb_select, reg_write_addr, alu_result, sign_extend,
    output data_r, reg_write_r, wb_select_r, reg_write_addr_r, alu_result_r,
           sign_extend_r, stall, stack_fault_r, addr_fault_r, sp
  );
endinterface

// File: rtl/stack_memory_stage.sv
// stack_memory_stage
//   MEM stage of the pipelined core: DEPTH-word data memory with a
//   downward-growing stack (SP points at the last pushed word), single and
//   double-word accesses, stack overflow/underflow and address-range faults,
//   and the MEM/WB pipeline register. Double-word operations take two cycles;
//   the first cycle raises stall and loads a bubble into MEM/WB.
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-low; clears everything except memory
//   bus   : request/response bundle (slave side)
module stack_memory_stage #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int SP_RESET = (1 << ADDR_W) - 1,
  parameter int RA_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  stack_memory_stage_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   SP_INIT = (ADDR_W+1)'(SP_RESET);
  localparam logic [ADDR_W:0]   SP_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   SP_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W+1:0] SP_LIM  = (ADDR_W+2)'(SP_RESET);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  typedef enum logic {S_IDLE, S_SECOND} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_READ, OP_WRITE, OP_PUSH, OP_POP} op_e;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  state_e              r_state, w_state_next;
  op_e                 r_op, w_op;
  logic [ADDR_W:0]     r_sp, w_sp_next;
  logic [DATA_W-1:0]   r_word, w_word_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [2*DATA_W-1:0] r_data, w_data_next;
  logic                r_reg_write, r_wb_select;
  logic [RA_W-1:0]     r_reg_write_addr;
  logic [DATA_W-1:0]   r_alu_result, r_sign_extend;
  logic                r_sfault, r_afault;

  logic                w_sfault, w_afault, w_fault;
  logic                w_stall, w_bubble, w_latch, w_we, w_mem_we;
  logic [ADDR_W-1:0]   w_waddr, w_addr_idx;
  logic [DATA_W-1:0]   w_wdata, w_wd_lo, w_wd_hi;
  logic                w_overflow, w_underflow, w_addr_bad;
  logic [ADDR_W:0]     w_need, w_sp_m1, w_sp_m2, w_sp_p1, w_sp_p2;
  logic [ADDR_W+1:0]   w_pop_end;
  logic [DATA_W-1:0]   w_rd_sp, w_rd_sp1, w_rd_addr, w_rd_addr1;

  assign w_addr_idx = bus.address[ADDR_W-1:0];
  assign w_wd_lo    = bus.write_data[DATA_W-1:0];
  assign w_wd_hi    = bus.write_data[2*DATA_W-1:DATA_W];

  always_comb begin
    w_op = OP_NONE;
    if (bus.mem_push)       w_op = OP_PUSH;
    else if (bus.mem_pop)   w_op = OP_POP;
    else if (bus.mem_write) w_op = OP_WRITE;
    else if (bus.mem_read)  w_op = OP_READ;
  end

  assign w_need      = bus.wide ? SP_TWO : SP_ONE;
  assign w_sp_m1     = r_sp - SP_ONE;
  assign w_sp_m2     = r_sp - SP_TWO;
  assign w_sp_p1     = r_sp + SP_ONE;
  assign w_sp_p2     = r_sp + SP_TWO;
  assign w_pop_end   = {1'b0, r_sp} + {1'b0, w_need};
  assign w_overflow  = r_sp < w_need;
  assign w_underflow = w_pop_end > SP_LIM;
  assign w_addr_bad  = (bus.address[DATA_W-1:ADDR_W] != '0) ||
                       (bus.wide && (w_addr_idx == '1));
  assign w_fault     = ((w_op == OP_PUSH) && w_overflow)  ||
                       ((w_op == OP_POP)  && w_underflow) ||
                       (((w_op == OP_READ) || (w_op == OP_WRITE)) && w_addr_bad);

  assign w_rd_sp    = r_mem[r_sp[ADDR_W-1:0]];
  assign w_rd_sp1   = r_mem[w_sp_p1[ADDR_W-1:0]];
  assign w_rd_addr  = r_mem[w_addr_idx];
  assign w_rd_addr1 = r_mem[r_addr + IDX_ONE];

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    w_latch      = 1'b0;
    w_we         = 1'b0;
    w_waddr      = '0;
    w_wdata      = '0;
    w_sp_next    = r_sp;
    w_word_next  = '0;
    w_data_next  = '0;
    w_sfault     = 1'b0;
    w_afault     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // First half of a wide op: move one word, keep the other half in
        // r_word, and load a bubble into MEM/WB while upstream is held.
        if (bus.wide && (w_op != OP_NONE) && !w_fault) begin
          w_state_next = S_SECOND;
          w_stall      = 1'b1;
          w_bubble     = 1'b1;
          w_latch      = 1'b1;
        end
        unique case (w_op)
          OP_PUSH: begin
            if (w_overflow) begin
              w_sfault = 1'b1;
            end else begin
              w_we    = 1'b1;
              w_waddr = w_sp_m1[ADDR_W-1:0];
              if (bus.wide) begin
                w_wdata     = w_wd_hi;
                w_word_next = w_wd_lo;
              end else begin
                w_wdata   = w_wd_lo;
                w_sp_next = w_sp_m1;
              end
            end
          end
          OP_POP: begin
            if (w_underflow) begin
              w_sfault = 1'b1;
            end else if (bus.wide) begin
              w_word_next = w_rd_sp;
            end else begin
              w_data_next = {{DATA_W{1'b0}}, w_rd_sp};
              w_sp_next   = w_sp_p1;
            end
          end
          OP_WRITE: begin
            if (w_addr_bad) begin
              w_afault = 1'b1;
            end else begin
              w_we        = 1'b1;
              w_waddr     = w_addr_idx;
              w_wdata     = w_wd_lo;
              w_word_next = w_wd_hi;
            end
          end
          OP_READ: begin
            if (w_addr_bad) begin
              w_afault = 1'b1;
            end else if (bus.wide) begin
              w_word_next = w_rd_addr;
            end else begin
              w_data_next = {{DATA_W{1'b0}}, w_rd_addr};
            end
          end
          default: ;
        endcase
      end
      S_SECOND: begin
        // SP is still untouched here, so addresses are relative to the
        // value it had when the wide op was accepted.
        w_state_next = S_IDLE;
        unique case (r_op)
          OP_PUSH: begin
            w_we      = 1'b1;
            w_waddr   = w_sp_m2[ADDR_W-1:0];
            w_wdata   = r_word;
            w_sp_next = w_sp_m2;
          end
          OP_POP: begin
            w_data_next = {w_rd_sp1, r_word};
            w_sp_next   = w_sp_p2;
          end
          OP_WRITE: begin
            w_we    = 1'b1;
            w_waddr = r_addr + IDX_ONE;
            w_wdata = r_word;
          end
          OP_READ: begin
            w_data_next = {w_rd_addr1, r_word};
          end
          default: ;
        endcase
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp             <= SP_INIT;
      r_op             <= OP_NONE;
      r_word           <= '0;
      r_addr           <= '0;
      r_data           <= '0;
      r_reg_write      <= 1'b0;
      r_wb_select      <= 1'b0;
      r_reg_write_addr <= '0;
      r_alu_result     <= '0;
      r_sign_extend    <= '0;
      r_sfault         <= 1'b0;
      r_afault         <= 1'b0;
    end else begin
      r_sp <= w_sp_next;
      if (w_latch) begin
        r_op   <= w_op;
        r_word <= w_word_next;
        r_addr <= w_addr_idx;
      end
      r_data           <= w_data_next;
      r_reg_write      <= bus.reg_write & ~w_bubble;
      r_wb_select      <= bus.wb_select;
      r_reg_write_addr <= bus.reg_write_addr;
      r_alu_result     <= bus.alu_result;
      r_sign_extend    <= bus.sign_extend;
      r_sfault         <= w_sfault;
      r_afault         <= w_afault;
    end
  end

  // Writes are blocked while reset is held so requests seen during reset
  // cannot disturb memory contents.
  assign w_mem_we = w_we & reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_waddr] <= w_wdata;
  end

  assign bus.data_r           = r_data;
  assign bus.reg_write_r      = r_reg_write;
  assign bus.wb_select_r      = r_wb_select;
  assign bus.reg_write_addr_r = r_reg_write_addr;
  assign bus.alu_result_r     = r_alu_result;
  assign bus.sign_extend_r    = r_sign_extend;
  assign bus.stack_fault_r    = r_sfault;
  assign bus.addr_fault_r     = r_afault;
  assign bus.sp               = r_sp;
  assign bus.stall            = w_stall & reset;
endmodule

// File: tb/tb_stack_memory_stage.sv
// tb_stack_memory_stage
//   Scoreboard bench: the driver computes each request's outcome with a
//   word-array/stack reference model and queues it; an independent monitor
//   pops and compares whenever a MEM/WB load completes (stall low).
module tb_stack_memory_stage;
  localparam int SPR   = 2047;
  localparam int DEPTH = 2048;

  logic clk;
  logic rst_n;

  stack_memory_stage_if #(.DATA_W(16), .ADDR_W(11), .RA_W(3)) bus ();

  stack_memory_stage #(
    .DATA_W(16), .ADDR_W(11), .SP_RESET(SPR), .RA_W(3)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rd, wr, push, pop, wide;
    logic [15:0] addr;
    logic [31:0] wd;
    bit rw, wbs;
    logic [2:0] rwa;
    logic [15:0] alu, sext;
  } req_t;

  typedef struct {
    logic [31:0] data;
    bit data_chk;
    int sp;
    bit sf, af, rw, wbs;
    logic [2:0] rwa;
    logic [15:0] alu, sext;
    int stalls;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  bit drv_active = 0;

  logic [15:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_sp  = SPR;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endfunction

  function automatic req_t mk(bit push, bit pop, bit wr, bit rd, bit wide,
                              logic [15:0] a, logic [31:0] wd);
    req_t r;
    r.push = push; r.pop = pop; r.wr = wr; r.rd = rd; r.wide = wide;
    r.addr = a; r.wd = wd;
    r.rw = 1'($urandom); r.wbs = 1'($urandom); r.rwa = 3'($urandom);
    r.alu = 16'($urandom); r.sext = 16'($urandom);
    return r;
  endfunction

  // Reference behaviour: pick the highest-priority request, check its limits,
  // then update the word array and stack depth directly.
  task automatic model(input req_t r, output exp_t e);
    int n;
    int a;
    n = r.wide ? 2 : 1;
    a = int'(r.addr);
    e = '{default: '0};
    e.data_chk = 1; e.rw = r.rw; e.wbs = r.wbs; e.rwa = r.rwa;
    e.alu = r.alu; e.sext = r.sext;
    if (r.push) begin
      if (m_sp < n) e.sf = 1;
      else begin
        if (r.wide) begin
          m_mem[m_sp-1] = r.wd[31:16]; m_wr[m_sp-1] = 1;
          m_mem[m_sp-2] = r.wd[15:0];  m_wr[m_sp-2] = 1;
        end else begin
          m_mem[m_sp-1] = r.wd[15:0];  m_wr[m_sp-1] = 1;
        end
        m_sp = m_sp - n;
        e.stalls = n - 1;
      end
    end else if (r.pop) begin
      if (m_sp + n > SPR) e.sf = 1;
      else begin
        e.data = {16'h0, m_mem[m_sp]};
        if (!m_wr[m_sp]) e.data_chk = 0;
        if (r.wide) begin
          e.data[31:16] = m_mem[m_sp+1];
          if (!m_wr[m_sp+1]) e.data_chk = 0;
        end
        m_sp = m_sp + n;
        e.stalls = n - 1;
      end
    end else if (r.wr || r.rd) begin
      if (a >= DEPTH || (r.wide && a == DEPTH-1)) e.af = 1;
      else if (r.wr) begin
        m_mem[a] = r.wd[15:0]; m_wr[a] = 1;
        if (r.wide) begin m_mem[a+1] = r.wd[31:16]; m_wr[a+1] = 1; end
        e.stalls = n - 1;
      end else begin
        e.data = {16'h0, m_mem[a]};
        if (!m_wr[a]) e.data_chk = 0;
        if (r.wide) begin
          e.data[31:16] = m_mem[a+1];
          if (!m_wr[a+1]) e.data_chk = 0;
        end
        e.stalls = n - 1;
      end
    end
    e.sp = m_sp;
  endtask

  task automatic drive(input req_t r);
    bus.mem_read = r.rd;  bus.mem_write = r.wr;
    bus.mem_push = r.push; bus.mem_pop = r.pop; bus.wide = r.wide;
    bus.address = r.addr; bus.write_data = r.wd;
    bus.reg_write = r.rw; bus.wb_select = r.wbs; bus.reg_write_addr = r.rwa;
    bus.alu_result = r.alu; bus.sign_extend = r.sext;
  endtask

  // Called at posedge+1; returns at the posedge+1 after the request completes.
  task automatic issue(input req_t r);
    exp_t e;
    int k;
    model(r, e);
    sb.push_back(e);
    drive(r);
    drv_active = 1;
    k = 0;
    @(negedge clk);
    while (bus.stall && k < 4) begin @(negedge clk); k++; end
    if (bus.stall) begin
      total++; bad++;
      $display("FAIL stall_timeout: stall still %0d after %0d cycles, required 0", bus.stall, k);
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    bit pend;
    int run, pend_run;
    pend = 0; run = 0; pend_run = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got no queued entry, required one");
        end else begin
          e = sb.pop_front();
          if (e.data_chk) chk("data_r", bus.data_r, e.data);
          chk("sp", bus.sp, e.sp);
          chk("stack_fault_r", bus.stack_fault_r, e.sf);
          chk("addr_fault_r", bus.addr_fault_r, e.af);
          chk("reg_write_r", bus.reg_write_r, e.rw);
          chk("wb_select_r", bus.wb_select_r, e.wbs);
          chk("reg_write_addr_r", bus.reg_write_addr_r, e.rwa);
          chk("alu_result_r", bus.alu_result_r, e.alu);
          chk("sign_extend_r", bus.sign_extend_r, e.sext);
          chk("stall_cycles", pend_run, e.stalls);
        end
      end
      pend = 0;
      if (drv_active && rst_n) begin
        if (bus.stall) run++;
        else begin pend = 1; pend_run = run; run = 0; end
      end else run = 0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_data_r"}, bus.data_r, 0);
    chk({tag, "_reg_write_r"}, bus.reg_write_r, 0);
    chk({tag, "_wb_select_r"}, bus.wb_select_r, 0);
    chk({tag, "_reg_write_addr_r"}, bus.reg_write_addr_r, 0);
    chk({tag, "_alu_result_r"}, bus.alu_result_r, 0);
    chk({tag, "_sign_extend_r"}, bus.sign_extend_r, 0);
    chk({tag, "_stack_fault_r"}, bus.stack_fault_r, 0);
    chk({tag, "_addr_fault_r"}, bus.addr_fault_r, 0);
    chk({tag, "_sp"}, bus.sp, SPR);
    chk({tag, "_stall"}, bus.stall, 0);
  endtask

  initial begin : stim
    req_t r;
    int a, guard;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_wr[i] = 0; end

    // Reset with a wide push requested: stall must stay low, nothing moves.
    rst_n = 1'b0;
    drive(mk(1, 0, 0, 0, 1, 16'h0, 32'hCAFE_F00D));
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    drive(mk(0, 0, 0, 0, 0, 16'h0, 32'h0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push/pop ordering.
    issue(mk(1, 0, 0, 0, 0, 16'h0, 32'h0000_1234));
    issue(mk(1, 0, 0, 0, 0, 16'h0, 32'h0000_5678));
    issue(mk(0, 1, 0, 0, 0, 16'h0, 32'h0));
    issue(mk(0, 1, 0, 0, 0, 16'h0, 32'h0));
    // Wide push, inspect both halves, wide pop.
    issue(mk(1, 0, 0, 0, 1, 16'h0, 32'hDEAD_BEEF));
    issue(mk(0, 0, 0, 1, 0, 16'd2046, 32'h0));
    issue(mk(0, 0, 0, 1, 0, 16'd2045, 32'h0));
    issue(mk(0, 1, 0, 0, 1, 16'h0, 32'h0));
    // Empty-stack pops.
    issue(mk(0, 1, 0, 0, 0, 16'h0, 32'h0));
    issue(mk(0, 1, 0, 0, 1, 16'h0, 32'h0));
    // Address faults; the faulty write must not alias onto index 0.
    issue(mk(0, 0, 1, 0, 0, 16'h0000, 32'h0000_1111));
    issue(mk(0, 0, 1, 0, 0, 16'h0800, 32'h0000_AAAA));
    issue(mk(0, 0, 0, 1, 0, 16'h0000, 32'h0));
    issue(mk(0, 0, 0, 1, 1, 16'h07FF, 32'h0));
    // Wide write then wide and single reads.
    issue(mk(0, 0, 1, 0, 1, 16'h0020, 32'h7654_3210));
    issue(mk(0, 0, 0, 1, 1, 16'h0020, 32'h0));
    issue(mk(0, 0, 0, 1, 0, 16'h0021, 32'h0));
    // Push wins over a simultaneous write.
    issue(mk(0, 0, 1, 0, 0, 16'h0010, 32'h0000_2222));
    issue(mk(1, 0, 1, 0, 0, 16'h0010, 32'h0000_3333));
    issue(mk(0, 0, 0, 1, 0, 16'h0010, 32'h0));
    issue(mk(0, 1, 0, 0, 0, 16'h0, 32'h0));
    // Pass-through on a non-memory instruction.
    r = mk(0, 0, 0, 0, 0, 16'h0, 32'h0);
    r.rw = 1; r.rwa = 3'd5; r.alu = 16'h00FF;
    issue(r);

    // Reset during the second cycle of a wide pop.
    issue(mk(1, 0, 0, 0, 1, 16'h0, 32'h1234_5678));
    drv_active = 0;
    drive(mk(0, 1, 0, 0, 1, 16'h0, 32'h0));
    @(negedge clk);
    chk("midrst_stall_first", bus.stall, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_sp = SPR;
    drive(mk(0, 0, 0, 0, 0, 16'h0, 32'h0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(mk(0, 0, 0, 1, 1, 16'd2045, 32'h0));

    // Random mix with overlapping requests.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0:       a = int'({5'($urandom_range(1, 31)), 11'($urandom)});
        1:       a = 16'h07FF;
        2, 3:    a = int'($urandom_range(0, 15));
        default: a = 16'h07F0 + int'($urandom_range(0, 15));
      endcase
      r = mk($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             1'($urandom), 16'(a), $urandom);
      issue(r);
    end

    // Fill down to SP = 1, then probe both overflow boundaries.
    while (m_sp > 1) issue(mk(1, 0, 0, 0, m_sp >= 3, 16'h0, $urandom));
    issue(mk(1, 0, 0, 0, 1, 16'h0, $urandom));
    issue(mk(1, 0, 0, 0, 0, 16'h0, $urandom));
    issue(mk(1, 0, 0, 0, 0, 16'h0, $urandom));
    issue(mk(1, 0, 0, 0, 1, 16'h0, $urandom));

    // Drain with mixed widths; ends on underflow attempts near the top.
    guard = 0;
    while (m_sp < SPR && guard < 4000) begin
      issue(mk(0, 1, 0, 0, 1'($urandom), 16'h0, 32'h0));
      guard++;
    end
    issue(mk(0, 1, 0, 0, 0, 16'h0, 32'h0));

    drv_active = 0;
    repeat (3) @(negedge clk);
    chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_memory_stage.md
# stack_memory_stage

Parametrised MEM-stage block for the pipelined RISC core: a DEPTH-word data memory with a downward-growing stack, now supporting single- and double-word accesses, stack overflow/underflow detection and out-of-range address detection. It sits between the EX/MEM boundary and write-back. It registers memory read data together with the write-back control fields (MEM/WB register), and raises a one-cycle stall for the first half of every double-word operation.

## Interface
Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 11, memory index width; DEPTH = 2**ADDR_W words
- SP_RESET, DEPTH-1, empty-stack value of SP
- RA_W, 3, register-file address width

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state except memory contents
- mem_read / mem_write / mem_push / mem_pop  in  1 each  operation requests
- wide  in  1  1 = double-word operation (2*DATA_W), 0 = single word
- address  in  DATA_W  word address for read/write
- write_data  in  2*DATA_W  store/push data; low word used when wide=0
- reg_write, wb_select  in  1 each  pass-through controls
- reg_write_addr  in  RA_W  pass-through destination register
- alu_result, sign_extend  in  DATA_W each  pass-through operands
- data_r  out  2*DATA_W  registered load/pop data; upper half 0 when wide=0
- reg_write_r, wb_select_r, reg_write_addr_r, alu_result_r, sign_extend_r  out  registered pass-throughs
- stall  out  1  combinational; upstream holds the EX/MEM register while high
- stack_fault_r  out  1  registered overflow/underflow flag
- addr_fault_r  out  1  registered out-of-range flag
- sp  out  ADDR_W+1  current stack pointer

## Operation
- SP points at the top (last pushed) word. Stack is empty when SP == SP_RESET; mem[SP_RESET] is never written by push.
- Only one operation is executed per request. Priority: push > pop > write > read; lower-priority requests in the same cycle are ignored.
- Single push: SP <= SP-1, then mem[SP-1] <= write_data[DATA_W-1:0].
- Single pop: data = mem[SP], then SP <= SP+1.
- Wide push: high word goes to mem[SP-1], low word to mem[SP-2]; SP decreases by 2.
- Wide pop: low word = mem[SP], high word = mem[SP+1]; SP increases by 2. Pop reassembles exactly what push stored.
- Wide read/write: low word at address, high word at address+1.
- Overflow: a push needing n words when SP < n. Underflow: a pop when SP+n > SP_RESET. On either fault: no memory write, SP unchanged, data_r = 0, stack_fault_r = 1 for one cycle, and no second cycle for wide operations.
- Address fault: address[DATA_W-1:ADDR_W] != 0, or wide with address[ADDR_W-1:0] == DEPTH-1. On fault: write suppressed, data_r = 0, addr_fault_r = 1 for one cycle.
- FSM:
  - IDLE → SECOND on an accepted, non-faulting wide operation. stall = 1 in that IDLE cycle; the first word is transferred.
  - SECOND → IDLE unconditionally. stall = 0; the second word is transferred, SP is finalised, and the MEM/WB register loads.
- No address arithmetic wraps: the fault checks guarantee SP and address stay within 0..SP_RESET.

## Timing
- Reset (reset = 0, asynchronous) forces: SP = SP_RESET, FSM = IDLE, every registered output = 0, stall = 0. Memory contents are undefined and not cleared.
- Reset asserted mid-wide-operation aborts it. The first word may already be written; SP returns to SP_RESET.
- Single-word operations and non-memory instructions: one cycle. Data and pass-throughs appear on *_r at the next posedge.
- Wide operations: two cycles, with data_r valid after the second posedge. During the stall cycle the MEM/WB register loads a bubble (reg_write_r = 0, data_r = 0); other *_r fields are don't-care.
- Request inputs are sampled only in IDLE. In SECOND the block uses the operation latched in IDLE, and inputs must remain held because of stall.
- Memory read is asynchronous (combinational into the MEM/WB register). Memory write is synchronous.

## Test plan
- Reset, then single push 0x1234, 0x5678, then two pops → sp 2047→2046→2045; data_r 0x5678 then 0x1234; sp back to 2047.
- Wide push 0xDEADBEEF then wide pop → stall high for exactly 1 cycle each; mem[2046] = 0xDEAD, mem[2045] = 0xBEEF; data_r = 0xDEADBEEF; sp back to 2047.
- Pop on empty stack → stack_fault_r = 1 for one cycle, data_r = 0, sp = 2047. Wide push with sp = 1 → fault, no write, sp = 1.
- Write 0xAAAA to address 0x0800 → addr_fault_r = 1, no write. Wide read at 0x07FF → addr_fault_r = 1, data_r = 0.
- Push and write asserted together → only the push executes; mem[address] is unchanged.
- Pass-through check: reg_write = 1, reg_write_addr = 5, alu_result = 0x00FF → all appear on *_r one cycle later. Assert reset low during the SECOND state of a wide pop → all outputs 0 immediately, sp = 2047, FSM = IDLE.
